axi_ram_slave: RTL and testbench

AXI3 slave responder backed by a word-organised on-chip RAM; it is the memory end of the 4-bit-ID, 32-bit AXI master port exported by the CPU top. It accepts single and burst reads and writes (FIXED/INCR/WRAP), one transaction at a time, with fair read/write arbitration. Used as the simulation and FPGA memory model behind the core and as a scratch RAM in SoC builds.

---
 rtl/axi_ram_slave_pkg.sv | 62 ++++++
 rtl/axi_burst_addr.sv | 48 ++++
 rtl/axi_ram_slave.sv | 237 +++++++++++++++++++++++
 tb/tb_axi_ram_slave.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_ram_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_ram_slave_pkg
// Description : Shared AXI3 definitions for the 4-bit-ID / 32-bit data port.
//               The package holds the field widths, the burst and response
//               codes, the slave FSM state type and the captured-address
//               structure. The core's bus interface reuses the same
//               definitions.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_ram_slave_pkg;

  // Field widths of the AXI port exported by the CPU top
  localparam int AXI_ID_W    = 4;
  localparam int AXI_ADDR_W  = 32;
  localparam int AXI_DATA_W  = 32;
  localparam int AXI_STRB_W  = AXI_DATA_W / 8;
  localparam int AXI_LEN_W   = 4;
  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_BURST_W = 2;
  localparam int AXI_RESP_W  = 2;

  // Largest legal beat size: 2 means 4 bytes, which is the full data bus
  localparam logic [AXI_SIZE_W-1:0] AXI_SIZE_MAX = 3'd2;

  typedef enum logic [AXI_BURST_W-1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } axi_burst_e;

  typedef enum logic [AXI_RESP_W-1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD      = 2'd1,
    ST_WR_DATA = 2'd2,
    ST_WR_RESP = 2'd3
  } state_e;

  // Captured address phase of the transaction in flight
  typedef struct packed {
    logic [AXI_ID_W-1:0]    id;
    logic [AXI_ADDR_W-1:0]  addr;
    logic [AXI_LEN_W-1:0]   len;
    logic [AXI_SIZE_W-1:0]  size;
    logic [AXI_BURST_W-1:0] burst;
  } axi_ax_t;

  // A WRAP burst must have 2, 4, 8 or 16 beats
  function automatic logic wrap_len_ok(input logic [AXI_LEN_W-1:0] len);
    return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_burst_addr.sv
`default_nettype none
// ============================================================================
// Module      : axi_burst_addr
// Description : Combinational AXI3 burst address stepper and legality check.
//   addr_i      current beat byte address
//   len_i       beats-1 of the burst
//   size_i      log2 of the bytes per beat
//   burst_i     FIXED / INCR / WRAP / reserved
//   next_addr_o byte address of the following beat
//   err_o       the burst cannot be served (size, reserved type, WRAP length)
// Revision    : 1.0 - initial release
// ============================================================================
module axi_burst_addr
  import axi_ram_slave_pkg::*;
(
  input  logic [AXI_ADDR_W-1:0]  addr_i,
  input  logic [AXI_LEN_W-1:0]   len_i,
  input  logic [AXI_SIZE_W-1:0]  size_i,
  input  logic [AXI_BURST_W-1:0] burst_i,
  output logic [AXI_ADDR_W-1:0]  next_addr_o,
  output logic                   err_o
);

  logic [AXI_ADDR_W-1:0] step;
  logic [AXI_ADDR_W-1:0] incr_addr;
  logic [AXI_ADDR_W-1:0] wrap_mask;

  always_comb begin
    step      = 32'd1 << size_i;
    incr_addr = addr_i + step;
    // The wrap window is (len+1)<<size bytes and aligned to its own size;
    // the bits below the mask advance, the bits above stay fixed.
    wrap_mask = (({28'd0, len_i} + 32'd1) << size_i) - 32'd1;

    err_o = (size_i > AXI_SIZE_MAX) ||
            (burst_i == BURST_RSVD) ||
            ((burst_i == BURST_WRAP) && !wrap_len_ok(len_i));

    case (burst_i)
      BURST_FIXED: next_addr_o = addr_i;
      BURST_INCR:  next_addr_o = incr_addr;
      BURST_WRAP:  next_addr_o = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr_o = addr_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/axi_ram_slave.sv
`default_nettype none
// ============================================================================
// Module      : axi_ram_slave
// Description : AXI3 slave responder backed by a word-organised RAM of
//               2^ADDR_W 32-bit words. It serves one transaction at a time
//               and alternates read/write priority when both address
//               channels are valid.
//   aclk, aresetn                clock and asynchronous active-low reset
//   s_ar* / s_arvalid/s_arready  read address channel
//   s_r*  / s_rvalid/s_rready    read data channel
//   s_aw* / s_awvalid/s_awready  write address channel
//   s_w*  / s_wvalid/s_wready    write data channel (s_wid unused)
//   s_b*  / s_bvalid/s_bready    write response channel
//   lock/cache/prot sidebands are accepted and ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_ram_slave
  import axi_ram_slave_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  // read address
  input  logic [AXI_ID_W-1:0]    s_arid,
  input  logic [AXI_ADDR_W-1:0]  s_araddr,
  input  logic [AXI_LEN_W-1:0]   s_arlen,
  input  logic [AXI_SIZE_W-1:0]  s_arsize,
  input  logic [AXI_BURST_W-1:0] s_arburst,
  input  logic [1:0]             s_arlock,
  input  logic [3:0]             s_arcache,
  input  logic [2:0]             s_arprot,
  input  logic                   s_arvalid,
  output logic                   s_arready,
  // read data
  output logic [AXI_ID_W-1:0]    s_rid,
  output logic [AXI_DATA_W-1:0]  s_rdata,
  output logic [AXI_RESP_W-1:0]  s_rresp,
  output logic                   s_rlast,
  output logic                   s_rvalid,
  input  logic                   s_rready,
  // write address
  input  logic [AXI_ID_W-1:0]    s_awid,
  input  logic [AXI_ADDR_W-1:0]  s_awaddr,
  input  logic [AXI_LEN_W-1:0]   s_awlen,
  input  logic [AXI_SIZE_W-1:0]  s_awsize,
  input  logic [AXI_BURST_W-1:0] s_awburst,
  input  logic [1:0]             s_awlock,
  input  logic [3:0]             s_awcache,
  input  logic [2:0]             s_awprot,
  input  logic                   s_awvalid,
  output logic                   s_awready,
  // write data
  input  logic [AXI_ID_W-1:0]    s_wid,
  input  logic [AXI_DATA_W-1:0]  s_wdata,
  input  logic [AXI_STRB_W-1:0]  s_wstrb,
  input  logic                   s_wlast,
  input  logic                   s_wvalid,
  output logic                   s_wready,
  // write response
  output logic [AXI_ID_W-1:0]    s_bid,
  output logic [AXI_RESP_W-1:0]  s_bresp,
  output logic                   s_bvalid,
  input  logic                   s_bready
);

  localparam int DEPTH = 1 << ADDR_W;

  state_e         state_q, state_d;
  axi_ax_t        txn_q, txn_d;
  logic [AXI_LEN_W-1:0] beat_q, beat_d;
  logic           wlast_err_q, wlast_err_d;
  logic           prio_w_q, prio_w_d;
  logic           up_q;

  logic [AXI_DATA_W-1:0] mem [DEPTH];

  logic [AXI_ADDR_W-1:0] next_addr;
  logic                  txn_err;
  logic                  last_beat;
  logic [ADDR_W-1:0]     ram_idx;
  logic                  ram_we;

  // Sideband fields carry no meaning for a plain RAM
  logic unused_inputs;
  assign unused_inputs = ^{s_arlock, s_arcache, s_arprot,
                           s_awlock, s_awcache, s_awprot, s_wid};

  axi_burst_addr u_burst_addr (
    .addr_i      (txn_q.addr),
    .len_i       (txn_q.len),
    .size_i      (txn_q.size),
    .burst_i     (txn_q.burst),
    .next_addr_o (next_addr),
    .err_o       (txn_err)
  );

  // Byte address bits above the RAM size alias onto the same words
  assign ram_idx   = txn_q.addr[ADDR_W+1:2];
  assign last_beat = (beat_q == txn_q.len);
  assign ram_we    = (state_q == ST_WR_DATA) && s_wvalid && !txn_err;

  // --------------------------------------------------------------------------
  // Next-state and channel outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    txn_d       = txn_q;
    beat_d      = beat_q;
    wlast_err_d = wlast_err_q;
    prio_w_d    = prio_w_q;

    s_arready = 1'b0;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_rvalid  = 1'b0;
    s_rid     = '0;
    s_rdata   = '0;
    s_rresp   = RESP_OKAY;
    s_rlast   = 1'b0;
    s_bvalid  = 1'b0;
    s_bid     = '0;
    s_bresp   = RESP_OKAY;

    case (state_q)
      ST_IDLE: begin
        // Each ready only yields when the other side is valid and holds
        // priority, so at most one address handshake fires per cycle.
        s_arready = up_q && !(s_awvalid && prio_w_q);
        s_awready = up_q && !(s_arvalid && !prio_w_q);
        if (s_arvalid && up_q && !(s_awvalid && prio_w_q)) begin
          txn_d.id    = s_arid;
          txn_d.addr  = s_araddr;
          txn_d.len   = s_arlen;
          txn_d.size  = s_arsize;
          txn_d.burst = s_arburst;
          beat_d      = '0;
          prio_w_d    = !prio_w_q;
          state_d     = ST_RD;
        end else if (s_awvalid && up_q && !(s_arvalid && !prio_w_q)) begin
          txn_d.id    = s_awid;
          txn_d.addr  = s_awaddr;
          txn_d.len   = s_awlen;
          txn_d.size  = s_awsize;
          txn_d.burst = s_awburst;
          beat_d      = '0;
          wlast_err_d = 1'b0;
          prio_w_d    = !prio_w_q;
          state_d     = ST_WR_DATA;
        end
      end

      ST_RD: begin
        s_rvalid = 1'b1;
        s_rid    = txn_q.id;
        // The whole word is returned; narrow reads pick their lanes
        s_rdata  = txn_err ? '0 : mem[ram_idx];
        s_rresp  = txn_err ? RESP_SLVERR : RESP_OKAY;
        s_rlast  = last_beat;
        if (s_rready) begin
          txn_d.addr = next_addr;
          beat_d     = beat_q + 4'd1;
          if (last_beat) begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_WR_DATA: begin
        s_wready = 1'b1;
        if (s_wvalid) begin
          txn_d.addr = next_addr;
          beat_d     = beat_q + 4'd1;
          // The beat count ends the burst; a wlast that disagrees with it
          // only poisons the response.
          if (s_wlast != last_beat) begin
            wlast_err_d = 1'b1;
          end
          if (last_beat) begin
            state_d = ST_WR_RESP;
          end
        end
      end

      ST_WR_RESP: begin
        s_bvalid = 1'b1;
        s_bid    = txn_q.id;
        s_bresp  = (txn_err || wlast_err_q) ? RESP_SLVERR : RESP_OKAY;
        if (s_bready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      txn_q       <= '0;
      beat_q      <= '0;
      wlast_err_q <= 1'b0;
      prio_w_q    <= 1'b0;
      up_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      txn_q       <= txn_d;
      beat_q      <= beat_d;
      wlast_err_q <= wlast_err_d;
      prio_w_q    <= prio_w_d;
      // Holds every ready low until the first edge after reset release
      up_q        <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // RAM: no reset, so contents survive a reset pulse. The write enable is
  // derived from the reset-cleared state, so an aborted burst writes nothing.
  // --------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (ram_we) begin
      for (int b = 0; b < AXI_STRB_W; b++) begin
        if (s_wstrb[b]) begin
          mem[ram_idx][8*b +: 8] <= s_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_ram_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_ram_slave
// Description : Directed self-checking bench for axi_ram_slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_ram_slave;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [3:0]  s_arid, s_awid, s_wid, s_rid, s_bid;
  logic [31:0] s_araddr, s_awaddr, s_wdata, s_rdata;
  logic [3:0]  s_arlen, s_awlen, s_wstrb;
  logic [2:0]  s_arsize, s_awsize;
  logic [1:0]  s_arburst, s_awburst, s_rresp, s_bresp;
  logic [1:0]  s_arlock, s_awlock;
  logic [3:0]  s_arcache, s_awcache;
  logic [2:0]  s_arprot, s_awprot;
  logic        s_arvalid, s_arready, s_awvalid, s_awready;
  logic        s_wlast, s_wvalid, s_wready;
  logic        s_rlast, s_rvalid, s_rready, s_bvalid, s_bready;

  int tests = 0;
  int fails = 0;

  always #5 aclk = ~aclk;

  axi_ram_slave #(.ADDR_W(12)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arlock(s_arlock), .s_arcache(s_arcache), .s_arprot(s_arprot),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awlock(s_awlock), .s_awcache(s_awcache), .s_awprot(s_awprot),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wid(s_wid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
  );

  // ---------------------------------------------------------------- channel drivers
  // All drivers start 1 time unit after a rising edge and return there.
  task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0; logic hs = 1'b0;
    s_arid = id; s_araddr = addr; s_arlen = len; s_arsize = size; s_arburst = burst;
    s_arvalid = 1'b1;
    while (!hs && n < 20) begin #2; hs = s_arready; @(posedge aclk); #1; n++; end
    s_arvalid = 1'b0;
    tests++;
    if (!hs) begin fails++; $display("FAIL ar_handshake: got timeout expected arready"); end
  endtask

  task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0; logic hs = 1'b0;
    s_awid = id; s_awaddr = addr; s_awlen = len; s_awsize = size; s_awburst = burst;
    s_awvalid = 1'b1;
    while (!hs && n < 20) begin #2; hs = s_awready; @(posedge aclk); #1; n++; end
    s_awvalid = 1'b0;
    tests++;
    if (!hs) begin fails++; $display("FAIL aw_handshake: got timeout expected awready"); end
  endtask

  task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0; logic hs = 1'b0;
    s_wdata = data; s_wstrb = strb; s_wlast = last; s_wvalid = 1'b1;
    while (!hs && n < 20) begin #2; hs = s_wready; @(posedge aclk); #1; n++; end
    s_wvalid = 1'b0;
    tests++;
    if (!hs) begin fails++; $display("FAIL w_handshake: got timeout expected wready"); end
  endtask

  task automatic b_recv(output logic [3:0] id, output logic [1:0] resp);
    int n = 0; logic hs = 1'b0;
    id = 'x; resp = 'x;
    s_bready = 1'b1;
    while (!hs && n < 20) begin
      #2; hs = s_bvalid; id = s_bid; resp = s_bresp; @(posedge aclk); #1; n++;
    end
    s_bready = 1'b0;
    tests++;
    if (!hs) begin fails++; $display("FAIL b_handshake: got timeout expected bvalid"); end
  endtask

  // Leaves rready high so consecutive calls take one beat per cycle
  task automatic r_recv(output logic [31:0] data, output logic [1:0] resp, output logic last,
                        output logic [3:0] id, output int waited);
    int n = 0; logic hs = 1'b0;
    data = 'x; resp = 'x; last = 'x; id = 'x;
    s_rready = 1'b1;
    while (!hs && n < 20) begin
      #2; hs = s_rvalid; data = s_rdata; resp = s_rresp; last = s_rlast; id = s_rid;
      @(posedge aclk); #1; n++;
    end
    waited = n - 1;
    tests++;
    if (!hs) begin fails++; $display("FAIL r_handshake: got timeout expected rvalid"); end
  endtask

  // ---------------------------------------------------------------- scenarios
  task automatic test_reset();
    aresetn = 1'b0; s_arvalid = 1'b1; s_awvalid = 1'b1;
    repeat (2) @(posedge aclk); #1;
    tests++;
    if ({s_arready, s_awready, s_wready, s_rvalid, s_rlast, s_bvalid} !== 6'b0) begin
      fails++; $display("FAIL reset_handshakes: got %b expected 000000",
                        {s_arready, s_awready, s_wready, s_rvalid, s_rlast, s_bvalid});
    end
    tests++;
    if ({s_rid, s_rdata, s_rresp, s_bid, s_bresp} !== 44'h0) begin
      fails++; $display("FAIL reset_payload: got %h expected 0",
                        {s_rid, s_rdata, s_rresp, s_bid, s_bresp});
    end
    s_arvalid = 1'b0; s_awvalid = 1'b0; aresetn = 1'b1; #1;
    tests++;
    if ({s_arready, s_awready} !== 2'b00) begin
      fails++; $display("FAIL ready_before_up: got %b expected 00", {s_arready, s_awready});
    end
    @(posedge aclk); #1;
    tests++;
    if ({s_arready, s_awready} !== 2'b11) begin
      fails++; $display("FAIL ready_after_up: got %b expected 11", {s_arready, s_awready});
    end
  endtask

  task automatic test_single();
    logic [31:0] d; logic [1:0] rs; logic l; logic [3:0] id; int w;
    aw_send(4'h3, 32'h1000, 4'd0, 3'd2, 2'b01);
    tests++;
    if (s_wready !== 1'b1) begin fails++; $display("FAIL single_wready: got %b expected 1", s_wready); end
    w_send(32'hDEADBEEF, 4'hF, 1'b1);
    tests++;
    if (s_bvalid !== 1'b1) begin fails++; $display("FAIL single_bvalid: got %b expected 1", s_bvalid); end
    b_recv(id, rs);
    tests++;
    if ({id, rs} !== {4'h3, 2'b00}) begin
      fails++; $display("FAIL single_b: got bid %h bresp %b expected 3 00", id, rs);
    end
    ar_send(4'h3, 32'h1000, 4'd0, 3'd2, 2'b01);
    r_recv(d, rs, l, id, w);
    s_rready = 1'b0;
    tests++;
    if ({d, rs, l, id} !== {32'hDEADBEEF, 2'b00, 1'b1, 4'h3} || w != 0) begin
      fails++; $display("FAIL single_r: got %h %b %b %h wait %0d expected deadbeef 00 1 3 wait 0",
                        d, rs, l, id, w);
    end
  endtask

  task automatic test_incr_burst();
    logic [31:0] d; logic [1:0] rs; logic l; logic [3:0] id; int w; int k; int cyc;
    aw_send(4'h1, 32'h20, 4'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) w_send(32'(i), 4'hF, i == 3);
    b_recv(id, rs);
    tests++;
    if (rs !== 2'b00) begin fails++; $display("FAIL incr_bresp: got %b expected 00", rs); end
    ar_send(4'h2, 32'h20, 4'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) begin
      r_recv(d, rs, l, id, w);
      tests++;
      if (d !== 32'(i) || l !== (i == 3) || w != 0 || id !== 4'h2) begin
        fails++; $display("FAIL incr_beat%0d: got %h last %b wait %0d id %h expected %h last %b wait 0 id 2",
                          i, d, l, w, id, i, i == 3);
      end
    end
    s_rready = 1'b0;
    // Stalled read: the presented beat must stay the expected one until taken
    ar_send(4'h2, 32'h20, 4'd3, 3'd2, 2'b01);
    k = 0; cyc = 0;
    while (k < 4 && cyc < 60) begin
      s_rready = (cyc == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      #2;
      if (s_rvalid) begin
        tests++;
        if (s_rdata !== 32'(k) || s_rlast !== (k == 3)) begin
          fails++; $display("FAIL stall_beat%0d: got %h last %b expected %h last %b",
                            k, s_rdata, s_rlast, k, k == 3);
        end
        if (s_rready) k++;
      end
      @(posedge aclk); #1; cyc++;
    end
    s_rready = 1'b0;
    tests++;
    if (k != 4) begin fails++; $display("FAIL stall_beats: got %0d expected 4", k); end
  endtask

  task automatic test_wrap();
    logic [31:0] d; logic [1:0] rs; logic l; logic [3:0] id; int w;
    logic [31:0] exp_incr [4];
    logic [31:0] exp_wrap [4];
    exp_incr = '{32'h102, 32'h103, 32'h100, 32'h101};
    exp_wrap = '{32'h1122CCDD, 32'h101, 32'h102, 32'h103};
    aw_send(4'h4, 32'h38, 4'd3, 3'd2, 2'b10);
    for (int i = 0; i < 4; i++) w_send(32'h100 + 32'(i), 4'hF, i == 3);
    b_recv(id, rs);
    ar_send(4'h4, 32'h30, 4'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) begin
      r_recv(d, rs, l, id, w);
      tests++;
      if (d !== exp_incr[i]) begin
        fails++; $display("FAIL wrap_write_beat%0d: got %h expected %h", i, d, exp_incr[i]);
      end
    end
    s_rready = 1'b0;
    aw_send(4'h4, 32'h38, 4'd0, 3'd2, 2'b01); w_send(32'h11223344, 4'hF, 1'b1); b_recv(id, rs);
    aw_send(4'h4, 32'h38, 4'd0, 3'd2, 2'b01); w_send(32'hAABBCCDD, 4'h3, 1'b1); b_recv(id, rs);
    ar_send(4'h4, 32'h38, 4'd3, 3'd2, 2'b10);
    for (int i = 0; i < 4; i++) begin
      r_recv(d, rs, l, id, w);
      tests++;
      if (d !== exp_wrap[i] || l !== (i == 3)) begin
        fails++; $display("FAIL wrap_read_beat%0d: got %h last %b expected %h last %b",
                          i, d, l, exp_wrap[i], i == 3);
      end
    end
    s_rready = 1'b0;
  endtask

  task automatic test_arbitration();
    logic [31:0] d; logic [1:0] rs; logic l; logic [3:0] id; int w;
    // Prior traffic ends on a write so read priority is current
    ar_send(4'h5, 32'h1000, 4'd0, 3'd2, 2'b01); r_recv(d, rs, l, id, w); s_rready = 1'b0;
    aw_send(4'h6, 32'h200, 4'd0, 3'd2, 2'b01); w_send(32'h11110200, 4'hF, 1'b1); b_recv(id, rs);
    // Pair 1: read wins
    s_arid = 4'h5; s_araddr = 32'h1000; s_arlen = 4'd0; s_arsize = 3'd2; s_arburst = 2'b01;
    s_awid = 4'h6; s_awaddr = 32'h200;  s_awlen = 4'd0; s_awsize = 3'd2; s_awburst = 2'b01;
    s_arvalid = 1'b1; s_awvalid = 1'b1; #2;
    tests++;
    if ({s_arready, s_awready} !== 2'b10) begin
      fails++; $display("FAIL arb1_ready: got %b expected 10", {s_arready, s_awready});
    end
    @(posedge aclk); #1; s_arvalid = 1'b0;
    r_recv(d, rs, l, id, w); s_rready = 1'b0;
    tests++;
    if (d !== 32'hDEADBEEF || id !== 4'h5) begin
      fails++; $display("FAIL arb1_read: got %h id %h expected deadbeef id 5", d, id);
    end
    aw_send(4'h6, 32'h200, 4'd0, 3'd2, 2'b01); w_send(32'h0000600D, 4'hF, 1'b1); b_recv(id, rs);
    tests++;
    if (id !== 4'h6) begin fails++; $display("FAIL arb1_bid: got %h expected 6", id); end
    // Lone read passes priority to the write side
    ar_send(4'h7, 32'h200, 4'd0, 3'd2, 2'b01); r_recv(d, rs, l, id, w); s_rready = 1'b0;
    tests++;
    if (d !== 32'h0000600D) begin fails++; $display("FAIL arb_lone_read: got %h expected 600d", d); end
    // Pair 2: write wins
    s_arid = 4'h8; s_araddr = 32'h200; s_awid = 4'h9; s_awaddr = 32'h204;
    s_arvalid = 1'b1; s_awvalid = 1'b1; #2;
    tests++;
    if ({s_arready, s_awready} !== 2'b01) begin
      fails++; $display("FAIL arb2_ready: got %b expected 01", {s_arready, s_awready});
    end
    @(posedge aclk); #1; s_awvalid = 1'b0;
    tests++;
    if ({s_wready, s_rvalid} !== 2'b10) begin
      fails++; $display("FAIL arb2_write_first: got %b expected 10", {s_wready, s_rvalid});
    end
    w_send(32'hBEEF0204, 4'hF, 1'b1); b_recv(id, rs);
    ar_send(4'h8, 32'h200, 4'd0, 3'd2, 2'b01); r_recv(d, rs, l, id, w); s_rready = 1'b0;
    tests++;
    if (d !== 32'h0000600D || id !== 4'h8) begin
      fails++; $display("FAIL arb2_read: got %h id %h expected 600d id 8", d, id);
    end
  endtask

  task automatic test_errors();
    logic [31:0] d; logic [1:0] rs; logic l; logic [3:0] id; int w;
    ar_send(4'h1, 32'h1000, 4'd1, 3'd2, 2'b11);
    for (int i = 0; i < 2; i++) begin
      r_recv(d, rs, l, id, w);
      tests++;
      if ({d, rs, l} !== {32'h0, 2'b10, 1'(i == 1)}) begin
        fails++; $display("FAIL rsvd_burst_beat%0d: got %h %b last %b expected 0 10 last %b",
                          i, d, rs, l, i == 1);
      end
    end
    s_rready = 1'b0;
    ar_send(4'h1, 32'h20, 4'd2, 3'd2, 2'b10);
    for (int i = 0; i < 3; i++) begin
      r_recv(d, rs, l, id, w);
      tests++;
      if ({d, rs} !== {32'h0, 2'b10}) begin
        fails++; $display("FAIL wrap_len_err_beat%0d: got %h %b expected 0 10", i, d, rs);
      end
    end
    s_rready = 1'b0;
    // Early wlast: all four beats still taken and written
    aw_send(4'h2, 32'h40, 4'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) w_send(32'h40 + 32'(i), 4'hF, i == 1);
    tests++;
    if (s_bvalid !== 1'b1) begin fails++; $display("FAIL wlast_beats: got bvalid %b expected 1", s_bvalid); end
    b_recv(id, rs);
    tests++;
    if (rs !== 2'b10) begin fails++; $display("FAIL wlast_bresp: got %b expected 10", rs); end
    ar_send(4'h2, 32'h40, 4'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) begin
      r_recv(d, rs, l, id, w);
      tests++;
      if ({d, rs} !== {32'h40 + 32'(i), 2'b00}) begin
        fails++; $display("FAIL wlast_data_beat%0d: got %h %b expected %h 00", i, d, rs, 32'h40 + i);
      end
    end
    s_rready = 1'b0;
    // Oversized beat: error response and no RAM update
    aw_send(4'h3, 32'h1000, 4'd0, 3'd3, 2'b01); w_send(32'h0, 4'hF, 1'b1); b_recv(id, rs);
    tests++;
    if (rs !== 2'b10) begin fails++; $display("FAIL size_err_bresp: got %b expected 10", rs); end
    ar_send(4'h3, 32'h1000, 4'd0, 3'd2, 2'b01); r_recv(d, rs, l, id, w); s_rready = 1'b0;
    tests++;
    if (d !== 32'hDEADBEEF) begin fails++; $display("FAIL size_err_nowrite: got %h expected deadbeef", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] rs; logic l; logic [3:0] id; int w;
    ar_send(4'h1, 32'h20, 4'd3, 3'd2, 2'b01);
    r_recv(d, rs, l, id, w);
    r_recv(d, rs, l, id, w);
    aresetn = 1'b0; #1;
    tests++;
    if ({s_rvalid, s_arready, s_awready} !== 3'b000) begin
      fails++; $display("FAIL midreset_outputs: got %b expected 000", {s_rvalid, s_arready, s_awready});
    end
    s_rready = 1'b0;
    @(posedge aclk); #1; aresetn = 1'b1; #1;
    tests++;
    if (s_arready !== 1'b0) begin fails++; $display("FAIL midreset_ready_early: got %b expected 0", s_arready); end
    @(posedge aclk); #1;
    tests++;
    if (s_arready !== 1'b1) begin fails++; $display("FAIL midreset_ready_up: got %b expected 1", s_arready); end
    ar_send(4'h1, 32'h20, 4'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) begin
      r_recv(d, rs, l, id, w);
      tests++;
      if (d !== 32'(i)) begin fails++; $display("FAIL midreset_ram%0d: got %h expected %h", i, d, i); end
    end
    s_rready = 1'b0;
  endtask

  initial begin
    aresetn = 1'b0;
    s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
    s_arlock = '0; s_arcache = '0; s_arprot = '0; s_arvalid = 1'b0;
    s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0;
    s_awlock = '0; s_awcache = '0; s_awprot = '0; s_awvalid = 1'b0;
    s_wid = '0; s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0;
    s_rready = 1'b0; s_bready = 1'b0;
    test_reset();
    test_single();
    test_arbitration();
    test_incr_burst();
    test_wrap();
    test_errors();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
